// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl
//   Request-side controller for one single-port, write-masked SRAM macro with a
//   one-cycle registered read. Turns a valid/ready request channel into RW0_*
//   strobes, captures read data in the only cycle it is valid, and buffers up to
//   two responses against downstream backpressure.
//
//   Optional feature, enabled by defining SRAM_CLEAR_ON_RESET_EN: after reset the
//   whole array is zero-filled (one word per cycle) before any request is taken.
//
// Ports
//   clock, reset          sole clock; synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_write             1 = write, 0 = read
//   req_addr/wmask/wdata  word address, per-lane write enable, write data
//   resp_valid/ready      read-response handshake
//   resp_rdata            read data, in request order
//   busy                  zero-fill sweep in progress
//   sram_en/wmode/addr/wmask/wdata  to macro RW0_en/wmode/addr/wmask/wdata
//   sram_rdata            from macro RW0_rdata
module sram_port_ctrl #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 84,
  parameter int unsigned MASK_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [MASK_W-1:0] req_wmask,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              busy,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  logic run;
  logic accept;

`ifdef SRAM_CLEAR_ON_RESET_EN
  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] sweep_q;
  logic              busy_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StClear;
      sweep_q <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        StClear: begin
          sweep_q <= sweep_q + 1'b1;
          if (&sweep_q) begin
            state_q <= StRun;
            busy_q  <= 1'b0;
          end
        end
        StRun: begin
          state_q <= StRun;
        end
        default: begin
          state_q <= StClear;
        end
      endcase
    end
  end

  assign run  = (state_q == StRun);
  assign busy = busy_q;
`else
  assign run  = 1'b1;
  assign busy = 1'b0;
`endif

  // Response buffer: two entries, pointers toggle between them.
  logic [DATA_W-1:0] fifo_mem_q [2];
  logic              fifo_rd_q;
  logic              fifo_wr_q;
  logic [1:0]        fifo_cnt_q;
  logic              inflight_q;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [1:0]        used;

  assign fifo_empty = (fifo_cnt_q == 2'd0);
  // Credits cover both buffered data and the read whose data lands next cycle.
  assign used       = fifo_cnt_q + {1'b0, inflight_q};
  assign req_ready  = run && !reset && (used < 2'd2);
  assign accept     = req_valid && req_ready;

  // Fresh macro data is only valid this cycle: deliver it or bank it.
  assign resp_valid = !reset && (!fifo_empty || inflight_q);
  assign resp_rdata = fifo_empty ? sram_rdata : fifo_mem_q[fifo_rd_q];
  assign pop        = !fifo_empty && resp_ready;
  assign push       = inflight_q && !(fifo_empty && resp_ready);

  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = req_addr;
    sram_wmask = req_wmask;
    sram_wdata = req_wdata;
`ifdef SRAM_CLEAR_ON_RESET_EN
    if (!run) begin
      sram_en    = !reset;
      sram_wmode = 1'b1;
      sram_addr  = sweep_q;
      sram_wmask = '1;
      sram_wdata = '0;
    end else
`endif
    if (accept) begin
      sram_en    = 1'b1;
      sram_wmode = req_write;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_q <= 1'b0;
      fifo_rd_q  <= 1'b0;
      fifo_wr_q  <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      inflight_q <= accept && !req_write;
      if (push) fifo_wr_q <= ~fifo_wr_q;
      if (pop)  fifo_rd_q <= ~fifo_rd_q;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem_q[fifo_wr_q] <= sram_rdata;
  end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: behavioural macro model, golden array with an
// expected-response queue, directed scenarios plus a randomized run.
module tb_sram_port_ctrl;
  localparam int AW = 7;
  localparam int DW = 84;
  localparam int MW = 4;
  localparam int LW = DW / MW;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [MW-1:0] req_wmask;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          busy;
  logic          sram_en, sram_wmode;
  logic [AW-1:0] sram_addr;
  logic [MW-1:0] sram_wmask;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;

  always #5 clock = ~clock;

  sram_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .busy(busy),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  int n_checks, n_fail, timeouts;

  function automatic logic [DW-1:0] garbage();
    logic [95:0] g;
    g = {$urandom(), $urandom(), $urandom()};
    return g[DW-1:0];
  endfunction

  // Macro model: registered read; output scrambled on any non-read cycle.
  logic [DW-1:0] mac_mem [DEPTH];
  always @(posedge clock) begin
    if (sram_en && sram_wmode) begin
      for (int l = 0; l < MW; l++)
        if (sram_wmask[l]) mac_mem[sram_addr][l*LW +: LW] <= sram_wdata[l*LW +: LW];
      sram_rdata <= garbage();
    end else if (sram_en) begin
      sram_rdata <= mac_mem[sram_addr];
    end else begin
      sram_rdata <= garbage();
    end
  end

  // Reference: array contents at request-acceptance order, expected responses.
  logic [DW-1:0] gold [DEPTH];
  logic [DW-1:0] exp_q[$], obs_q[$];
  int            acc_cyc_q[$], rsp_cyc_q[$];
  int            cyc = 0, rd_acc = 0, rsp_cnt = 0;

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      exp_q.delete(); obs_q.delete(); acc_cyc_q.delete(); rsp_cyc_q.delete();
      rd_acc = 0; rsp_cnt = 0;
`ifdef SRAM_CLEAR_ON_RESET_EN
      for (int i = 0; i < DEPTH; i++) gold[i] = '0;
`endif
    end else begin
      if (req_valid && req_ready) begin
        if (req_write) begin
          for (int l = 0; l < MW; l++)
            if (req_wmask[l]) gold[req_addr][l*LW +: LW] = req_wdata[l*LW +: LW];
        end else begin
          exp_q.push_back(gold[req_addr]);
          acc_cyc_q.push_back(cyc);
          rd_acc++;
        end
      end
      if (resp_valid && resp_ready) begin
        obs_q.push_back(resp_rdata);
        rsp_cyc_q.push_back(cyc);
        rsp_cnt++;
      end
    end
  end

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [MW-1:0] m,
                       input logic [DW-1:0] d);
    bit ok;
    ok = 0;
    req_valid = 1; req_write = w; req_addr = a; req_wmask = m; req_wdata = d;
    for (int i = 0; i < 200; i++) begin
      if (req_ready) begin
        @(negedge clock);
        ok = 1;
        break;
      end
      @(negedge clock);
    end
    req_valid = 0;
    if (!ok) timeouts++;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    resp_ready = 1;
    for (int i = 0; i < 64; i++) begin
      if (rd_acc == rsp_cnt) begin
        ok = 1;
        break;
      end
      @(negedge clock);
    end
    if (!ok) timeouts++;
  endtask

  task automatic count_sweep(output int cycles, output int bad);
    cycles = 0; bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      if (sram_en !== 1'b1 || sram_wmode !== 1'b1 || sram_wmask !== {MW{1'b1}} ||
          sram_wdata !== {DW{1'b0}} || sram_addr !== AW'(cycles)) bad++;
      cycles++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    int cycles, bad;
    reset = 1;
    repeat (3) @(negedge clock);
    n_checks += 3;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready got %b want 0", req_ready); end
    if (sram_en !== 1'b0) begin n_fail++; $display("FAIL rst_sram_en got %b want 0", sram_en); end
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
    reset = 0;
    #1;
`ifdef SRAM_CLEAR_ON_RESET_EN
    n_checks += 3;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL post_rst_busy got %b want 1", busy); end
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL post_rst_ready got %b want 0", req_ready); end
    if (sram_en !== 1'b1) begin n_fail++; $display("FAIL post_rst_en got %b want 1", sram_en); end
    count_sweep(cycles, bad);
    n_checks += 3;
    if (cycles != DEPTH) begin n_fail++; $display("FAIL sweep_len got %0d want %0d", cycles, DEPTH); end
    if (bad != 0) begin n_fail++; $display("FAIL sweep_strobes got %0d bad cycles want 0", bad); end
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL sweep_done_ready got %b want 1", req_ready); end
`else
    n_checks += 3;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_busy got %b want 0", busy); end
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready got %b want 1", req_ready); end
    if (sram_en !== 1'b0) begin n_fail++; $display("FAIL post_rst_en got %b want 0", sram_en); end
    @(negedge clock);
    for (int a = 0; a < DEPTH; a++) issue(1'b1, AW'(a), {MW{1'b1}}, {DW{1'b0}});
`endif
    @(negedge clock);
  endtask

  task automatic test_read_zero();
    issue(1'b0, AW'(5), '0, '0);
    drain();
    n_checks += 2;
    if (obs_q.size() != 1) begin
      n_fail++; $display("FAIL zero_count got %0d want 1", obs_q.size());
    end else if (obs_q[0] !== {DW{1'b0}}) begin
      n_fail++; $display("FAIL zero_data got %h want 0", obs_q[0]);
    end
    if (timeouts != 0) begin n_fail++; $display("FAIL zero_timeout got %0d want 0", timeouts); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_mask();
    logic [DW-1:0] d, want;
    d = garbage();
    d[15:0] = 16'hABCD;
    issue(1'b1, AW'(3), 4'b1111, d);
    issue(1'b1, AW'(3), 4'b0001, {garbage()} & ~{{(DW-LW){1'b0}}, {LW{1'b1}}} | DW'(21'h12345));
    issue(1'b0, AW'(3), '0, '0);
    drain();
    want = {d[DW-1:LW], 21'h12345};
    n_checks += 1;
    if (obs_q.size() != 1 || obs_q[0] !== want) begin
      n_fail++;
      $display("FAIL mask_merge got %h want %h", (obs_q.size() > 0) ? obs_q[0] : 'x, want);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 10; a++) issue(1'b1, AW'(a), {MW{1'b1}}, garbage());
    obs_q.delete(); exp_q.delete(); acc_cyc_q.delete(); rsp_cyc_q.delete();
    resp_ready = 1;
    for (int a = 0; a < 10; a++) issue(1'b0, AW'(a), '0, '0);
    drain();
    n_checks += 2;
    if (obs_q.size() != 10) begin n_fail++; $display("FAIL b2b_count got %0d want 10", obs_q.size()); end
    if (acc_cyc_q[9] - acc_cyc_q[0] != 9) begin
      n_fail++; $display("FAIL b2b_rate got %0d cycles want 9", acc_cyc_q[9] - acc_cyc_q[0]);
    end
    for (int i = 0; i < 10 && i < obs_q.size(); i++) begin
      n_checks += 2;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL b2b_data[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
      if (rsp_cyc_q[i] != acc_cyc_q[i] + 1) begin
        n_fail++; $display("FAIL b2b_latency[%0d] got %0d want %0d", i, rsp_cyc_q[i], acc_cyc_q[i] + 1);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    int idx;
    resp_ready = 0; req_write = 0; req_wmask = '0; req_wdata = '0;
    idx = 0; req_addr = '0; req_valid = 1;
    for (int c = 0; c < 6; c++) begin
      if (req_ready) idx++;
      @(negedge clock);
      req_addr = AW'(idx);
      if (idx >= 4) req_valid = 0;
    end
    n_checks += 3;
    if (idx != 2) begin n_fail++; $display("FAIL bp_accepts got %0d want 2", idx); end
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %b want 0", req_ready); end
    if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_resp_valid got %b want 1", resp_valid); end
    resp_ready = 1;
    #1;
    n_checks += 1;
    if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_same_cycle got %b want 0", req_ready); end
    @(negedge clock);
    n_checks += 1;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_return got %b want 1", req_ready); end
    for (int c = 0; c < 20 && idx < 4; c++) begin
      if (req_ready) idx++;
      @(negedge clock);
      req_addr = AW'(idx);
    end
    req_valid = 0;
    drain();
    n_checks += 2;
    if (idx != 4) begin n_fail++; $display("FAIL bp_total got %0d want 4", idx); end
    if (obs_q.size() != 4) begin n_fail++; $display("FAIL bp_count got %0d want 4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      n_checks += 1;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL bp_data[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_hazard();
    logic [DW-1:0] old;
    old = garbage();
    issue(1'b1, AW'(8), {MW{1'b1}}, old);
    resp_ready = 0;
    issue(1'b0, AW'(8), '0, '0);
    issue(1'b1, AW'(8), {MW{1'b1}}, DW'(8'h55));
    repeat (3) @(negedge clock);
    n_checks += 2;
    if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL haz_valid got %b want 1", resp_valid); end
    if (resp_rdata !== old) begin n_fail++; $display("FAIL haz_old got %h want %h", resp_rdata, old); end
    drain();
    obs_q.delete(); exp_q.delete();
    issue(1'b0, AW'(8), '0, '0);
    drain();
    n_checks += 1;
    if (obs_q.size() != 1 || obs_q[0] !== DW'(8'h55)) begin
      n_fail++; $display("FAIL haz_new got %h want %h", (obs_q.size() > 0) ? obs_q[0] : 'x, DW'(8'h55));
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    bit acc;
    int outst, n;
    acc = 0;
    for (int c = 0; c < 400; c++) begin
      outst = rd_acc - rsp_cnt;
      n_checks += 2;
      if (req_ready !== (outst < 2)) begin
        n_fail++; $display("FAIL rand_ready cyc %0d got %b want %b", c, req_ready, outst < 2);
      end
      if (resp_valid !== (outst > 0)) begin
        n_fail++; $display("FAIL rand_resp_valid cyc %0d got %b want %b", c, resp_valid, outst > 0);
      end
      if (acc) req_valid = 0;
      if (!req_valid && $urandom_range(0, 3) != 0) begin
        req_valid = 1;
        req_write = 1'($urandom_range(0, 1));
        req_addr  = AW'($urandom_range(0, 15));
        req_wmask = MW'($urandom());
        req_wdata = garbage();
      end
      resp_ready = ($urandom_range(0, 2) != 0);
      acc = req_valid && req_ready;
      @(negedge clock);
    end
    req_valid = 0;
    drain();
    n = exp_q.size();
    n_checks += 1;
    if (obs_q.size() != n) begin n_fail++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), n); end
    for (int i = 0; i < n && i < obs_q.size(); i++) begin
      n_checks += 1;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rand_data[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int cycles, bad, seen;
    bit found;
`ifdef SRAM_CLEAR_ON_RESET_EN
    reset = 1;
    @(negedge clock);
    reset = 0;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (busy && sram_addr == AW'(60)) begin found = 1; break; end
    end
    reset = 1;
    #1;
    n_checks += 2;
    if (!found) begin n_fail++; $display("FAIL mid_sweep_reach got %b want 1", found); end
    if (sram_en !== 1'b0) begin n_fail++; $display("FAIL mid_sweep_en got %b want 0", sram_en); end
    @(negedge clock);
    reset = 0;
    #1;
    count_sweep(cycles, bad);
    n_checks += 2;
    if (cycles != DEPTH) begin n_fail++; $display("FAIL resweep_len got %0d want %0d", cycles, DEPTH); end
    if (bad != 0) begin n_fail++; $display("FAIL resweep_strobes got %0d bad want 0", bad); end
    @(negedge clock);
`endif
    resp_ready = 1;
    issue(1'b0, AW'(2), '0, '0);
    reset = 1;
    #1;
    seen = resp_valid ? 1 : 0;
    @(negedge clock);
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (resp_valid) seen++;
      @(negedge clock);
    end
    n_checks += 2;
    if (seen != 0) begin n_fail++; $display("FAIL inflight_reset_valid got %0d cycles want 0", seen); end
    if (rsp_cnt != 0) begin n_fail++; $display("FAIL inflight_reset_resp got %0d want 0", rsp_cnt); end
`ifdef SRAM_CLEAR_ON_RESET_EN
    for (int i = 0; i < 200 && busy; i++) @(negedge clock);
`endif
    n_checks += 1;
    if (timeouts != 0) begin n_fail++; $display("FAIL wait_timeouts got %0d want 0", timeouts); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; timeouts = 0;
    reset = 1; req_valid = 0; req_write = 0; req_addr = '0; req_wmask = '0; req_wdata = '0;
    resp_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      mac_mem[i] = garbage();
      gold[i] = 'x;
    end
    @(negedge clock);
    test_reset();
    test_read_zero();
    test_mask();
    test_back_to_back();
    test_backpressure();
    test_hazard();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
